// File: rtl/t01_ai_pkg.sv
// Shared types, board geometry and default scoring weights for the AI placement evaluator.
// Optional build macro: T01_AI_CENTER_TIEBREAK_EN (center-biased tie-break, used by the top).
package t01_ai_pkg;

  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_BITS = BOARD_ROWS * BOARD_COLS;

  localparam int DEF_W_LINES  = 8;
  localparam int DEF_W_HEIGHT = 5;
  localparam int DEF_W_HOLES  = 7;
  localparam int DEF_W_BUMP   = 2;
  localparam int unsigned DEF_SCORE_W = 16;

  typedef logic signed [DEF_SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAND,
    ST_EVAL,
    ST_COMPARE,
    ST_DONE
  } eval_state_e;

  // Number of completely filled rows in a merged board.
  function automatic logic [4:0] count_full_rows(input logic [BOARD_BITS-1:0] b);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int r = 0; r < int'(BOARD_ROWS); r++) begin
      if (&b[8'(r * int'(BOARD_COLS)) +: BOARD_COLS]) cnt = cnt + 5'd1;
    end
    return cnt;
  endfunction

  // Distance of an x position from the board center column.
  function automatic logic [3:0] center_dist(input logic [3:0] x);
    return (x >= 4'd4) ? (x - 4'd4) : (4'd4 - x);
  endfunction

endpackage

// File: rtl/t01_ai_placement_evaluator_column_stats.sv
// Combinational height and hole count for one 20-cell board column (bit 0 = top row).
module t01_ai_column_stats
  import t01_ai_pkg::*;
(
  input  logic [BOARD_ROWS-1:0] col_bits,
  output logic [4:0]            height,
  output logic [4:0]            holes
);

  logic       found;
  logic [4:0] top;

  // Scan top to bottom: first set cell fixes the height, later clear cells are holes.
  always_comb begin
    found = 1'b0;
    top   = 5'd0;
    holes = 5'd0;
    for (int r = 0; r < int'(BOARD_ROWS); r++) begin
      if (col_bits[r] && !found) begin
        found = 1'b1;
        top   = 5'(r);
      end else if (found && !col_bits[r]) begin
        holes = holes + 5'd1;
      end
    end
    height = found ? 5'(int'(BOARD_ROWS) - int'(top)) : 5'd0;
  end

endmodule

// File: rtl/t01_ai_placement_evaluator.sv
// Streaming candidate scorer: column-serial heuristic, keeps only the best rotation/x.
// Optional build macro: T01_AI_CENTER_TIEBREAK_EN prefers x nearer the center on equal score.
module t01_ai_placement_evaluator
  import t01_ai_pkg::*;
#(
  parameter int          W_LINES  = DEF_W_LINES,
  parameter int          W_HEIGHT = DEF_W_HEIGHT,
  parameter int          W_HOLES  = DEF_W_HOLES,
  parameter int          W_BUMP   = DEF_W_BUMP,
  parameter int unsigned SCORE_W  = DEF_SCORE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cand_valid,
  output logic                      cand_ready,
  input  logic [BOARD_BITS-1:0]     cand_board,
  input  logic [1:0]                cand_rot,
  input  logic [3:0]                cand_x,
  input  logic                      cand_last,
  input  logic                      no_cand,
  output logic                      best_valid,
  output logic                      best_found,
  output logic [1:0]                best_rot,
  output logic [3:0]                best_x,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [5:0]                num_evaluated
);

  eval_state_e               state_q, state_d;
  logic [BOARD_BITS-1:0]     board_q, board_d;
  logic [1:0]                rot_q, rot_d;
  logic [3:0]                x_q, x_d;
  logic                      last_q, last_d;
  logic [4:0]                lines_q, lines_d;
  logic [3:0]                col_q, col_d;
  logic [7:0]                agg_q, agg_d;
  logic [7:0]                holes_q, holes_d;
  logic [7:0]                bump_q, bump_d;
  logic [4:0]                prev_h_q, prev_h_d;
  logic                      best_valid_q, best_valid_d;
  logic                      best_found_q, best_found_d;
  logic [1:0]                best_rot_q, best_rot_d;
  logic [3:0]                best_x_q, best_x_d;
  logic signed [SCORE_W-1:0] best_score_q, best_score_d;
  logic [5:0]                num_q, num_d;

  logic [BOARD_ROWS-1:0]     col_slice;
  logic [4:0]                col_height, col_holes, h_diff;
  logic signed [SCORE_W-1:0] score_c;
  logic                      replace_c;

  // Extract the column currently being scored.
  always_comb begin
    for (int r = 0; r < int'(BOARD_ROWS); r++) begin
      col_slice[r] = board_q[8'(r * int'(BOARD_COLS) + int'(col_q))];
    end
  end

  t01_ai_column_stats u_column_stats (
    .col_bits (col_slice),
    .height   (col_height),
    .holes    (col_holes)
  );

  assign h_diff  = (col_height >= prev_h_q) ? (col_height - prev_h_q) : (prev_h_q - col_height);
  assign score_c = SCORE_W'(W_LINES * int'(lines_q) - W_HEIGHT * int'(agg_q)
                            - W_HOLES * int'(holes_q) - W_BUMP * int'(bump_q));

`ifdef T01_AI_CENTER_TIEBREAK_EN
  assign replace_c = (score_c > best_score_q) ||
                     ((score_c == best_score_q) && (center_dist(x_q) < center_dist(best_x_q)));
`else
  assign replace_c = (score_c > best_score_q);
`endif

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    rot_d        = rot_q;
    x_d          = x_q;
    last_d       = last_q;
    lines_d      = lines_q;
    col_d        = col_q;
    agg_d        = agg_q;
    holes_d      = holes_q;
    bump_d       = bump_q;
    prev_h_d     = prev_h_q;
    best_valid_d = best_valid_q;
    best_found_d = best_found_q;
    best_rot_d   = best_rot_q;
    best_x_d     = best_x_q;
    best_score_d = best_score_q;
    num_d        = num_q;

    case (state_q)
      ST_WAIT_CAND: begin
        if (cand_valid) begin
          board_d  = cand_board;
          rot_d    = cand_rot;
          x_d      = cand_x;
          last_d   = cand_last;
          lines_d  = count_full_rows(cand_board);
          col_d    = 4'd0;
          agg_d    = 8'd0;
          holes_d  = 8'd0;
          bump_d   = 8'd0;
          prev_h_d = 5'd0;
          state_d  = ST_EVAL;
        end else if (no_cand) begin
          best_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_EVAL: begin
        agg_d    = agg_q + 8'(col_height);
        holes_d  = holes_q + 8'(col_holes);
        prev_h_d = col_height;
        if (col_q != 4'd0) bump_d = bump_q + 8'(h_diff);
        if (col_q == 4'(BOARD_COLS - 1)) state_d = ST_COMPARE;
        else                             col_d   = col_q + 4'd1;
      end
      ST_COMPARE: begin
        if (!best_found_q || replace_c) begin
          best_rot_d   = rot_q;
          best_x_d     = x_q;
          best_score_d = score_c;
        end
        best_found_d = 1'b1;
        if (num_q != 6'd63) num_d = num_q + 6'd1;
        if (last_q) begin
          best_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_WAIT_CAND;
        end
      end
      default: ;
    endcase

    // start from any state clears the result and reopens the candidate stream.
    if (start) begin
      best_valid_d = 1'b0;
      best_found_d = 1'b0;
      best_rot_d   = 2'd0;
      best_x_d     = 4'd0;
      best_score_d = '0;
      num_d        = 6'd0;
      state_d      = ST_WAIT_CAND;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      board_q      <= '0;
      rot_q        <= 2'd0;
      x_q          <= 4'd0;
      last_q       <= 1'b0;
      lines_q      <= 5'd0;
      col_q        <= 4'd0;
      agg_q        <= 8'd0;
      holes_q      <= 8'd0;
      bump_q       <= 8'd0;
      prev_h_q     <= 5'd0;
      best_valid_q <= 1'b0;
      best_found_q <= 1'b0;
      best_rot_q   <= 2'd0;
      best_x_q     <= 4'd0;
      best_score_q <= '0;
      num_q        <= 6'd0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      rot_q        <= rot_d;
      x_q          <= x_d;
      last_q       <= last_d;
      lines_q      <= lines_d;
      col_q        <= col_d;
      agg_q        <= agg_d;
      holes_q      <= holes_d;
      bump_q       <= bump_d;
      prev_h_q     <= prev_h_d;
      best_valid_q <= best_valid_d;
      best_found_q <= best_found_d;
      best_rot_q   <= best_rot_d;
      best_x_q     <= best_x_d;
      best_score_q <= best_score_d;
      num_q        <= num_d;
    end
  end

  assign cand_ready    = (state_q == ST_WAIT_CAND);
  assign best_valid    = best_valid_q;
  assign best_found    = best_found_q;
  assign best_rot      = best_rot_q;
  assign best_x        = best_x_q;
  assign best_score    = best_score_q;
  assign num_evaluated = num_q;

endmodule

// File: tb/tb_t01_ai_placement_evaluator.sv
// Directed bench for the AI placement evaluator with hand-computed scores.
module tb_t01_ai_placement_evaluator;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               cand_valid;
  logic               cand_ready;
  logic [199:0]       cand_board;
  logic [1:0]         cand_rot;
  logic [3:0]         cand_x;
  logic               cand_last;
  logic               no_cand;
  logic               best_valid;
  logic               best_found;
  logic [1:0]         best_rot;
  logic [3:0]         best_x;
  logic signed [15:0] best_score;
  logic [5:0]         num_evaluated;

  int checks   = 0;
  int failures = 0;

  logic [199:0] brd_a, brd_b, brd_full, brd_hole;
  int           n;
  int           exp_tie_x, exp_tie_rot;

  t01_ai_placement_evaluator dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cand_valid    (cand_valid),
    .cand_ready    (cand_ready),
    .cand_board    (cand_board),
    .cand_rot      (cand_rot),
    .cand_x        (cand_x),
    .cand_last     (cand_last),
    .no_cand       (no_cand),
    .best_valid    (best_valid),
    .best_found    (best_found),
    .best_rot      (best_rot),
    .best_x        (best_x),
    .best_score    (best_score),
    .num_evaluated (num_evaluated)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for cand_ready, then transfer one candidate.
  task automatic send_cand(input logic [199:0] b, input logic [1:0] rot,
                           input logic [3:0] x, input logic last);
    int k;
    k = 0;
    while (!cand_ready && k < 50) begin
      tick();
      k++;
    end
    if (!cand_ready) check_eq("ready_timeout", 0, 1);
    cand_board = b;
    cand_rot   = rot;
    cand_x     = x;
    cand_last  = last;
    cand_valid = 1'b1;
    tick();
    cand_valid = 1'b0;
    cand_last  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!best_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    if (!best_valid) check_eq("done_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cand_valid = 1'b0; cand_board = '0;
    cand_rot = 2'd0; cand_x = 4'd0; cand_last = 1'b0; no_cand = 1'b0;

    brd_a = '0;    brd_a[193:190] = 4'hF;
    brd_b = '0;    brd_b[160] = 1'b1; brd_b[170] = 1'b1; brd_b[180] = 1'b1; brd_b[190] = 1'b1;
    brd_full = '0; brd_full[199:190] = 10'h3FF;
    brd_hole = '0; brd_hole[180] = 1'b1;
`ifdef T01_AI_CENTER_TIEBREAK_EN
    exp_tie_x = 4; exp_tie_rot = 2;
`else
    exp_tie_x = 0; exp_tie_rot = 1;
`endif

    tick(); tick();
    check_eq("rst_best_valid", int'(best_valid), 0);
    check_eq("rst_cand_ready", int'(cand_ready), 0);
    check_eq("rst_num", int'(num_evaluated), 0);
    reset = 1'b0;
    tick();
    check_eq("idle_ready", int'(cand_ready), 0);

    // Single last candidate, row 19 cols 0-3.
    pulse_start();
    check_eq("wait_ready", int'(cand_ready), 1);
    send_cand(brd_a, 2'd1, 4'd0, 1'b1);
    wait_done(n);
    check_eq("single_latency", n, 11);
    check_eq("single_found", int'(best_found), 1);
    check_eq("single_score", int'(best_score), -22);
    check_eq("single_rot", int'(best_rot), 1);
    check_eq("single_x", int'(best_x), 0);
    check_eq("single_num", int'(num_evaluated), 1);

    // Two candidates: better one first; measure ready-low gap.
    pulse_start();
    check_eq("start_clears_valid", int'(best_valid), 0);
    send_cand(brd_a, 2'd1, 4'd0, 1'b0);
    n = 0;
    while (!cand_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("ready_low_gap", n, 11);
    send_cand(brd_b, 2'd0, 4'd0, 1'b1);
    wait_done(n);
    check_eq("two_rot", int'(best_rot), 1);
    check_eq("two_score", int'(best_score), -22);
    check_eq("two_num", int'(num_evaluated), 2);

    // Full row scoring.
    pulse_start();
    send_cand(brd_full, 2'd2, 4'd3, 1'b1);
    wait_done(n);
    check_eq("full_row_score", int'(best_score), -42);
    check_eq("full_row_x", int'(best_x), 3);

    // Hole scoring, and a later better candidate replaces the incumbent.
    pulse_start();
    send_cand(brd_full, 2'd2, 4'd3, 1'b0);
    send_cand(brd_hole, 2'd3, 4'd5, 1'b1);
    wait_done(n);
    check_eq("hole_score", int'(best_score), -21);
    check_eq("hole_rot", int'(best_rot), 3);
    check_eq("hole_x", int'(best_x), 5);

    // Equal scores at x=0 then x=4.
    pulse_start();
    send_cand(brd_a, 2'd1, 4'd0, 1'b0);
    send_cand(brd_a, 2'd2, 4'd4, 1'b1);
    wait_done(n);
    check_eq("tie_x", int'(best_x), exp_tie_x);
    check_eq("tie_rot", int'(best_rot), exp_tie_rot);
    check_eq("tie_score", int'(best_score), -22);

    // Zero placements.
    pulse_start();
    no_cand = 1'b1;
    tick();
    no_cand = 1'b0;
    check_eq("nocand_valid", int'(best_valid), 1);
    check_eq("nocand_found", int'(best_found), 0);
    check_eq("nocand_num", int'(num_evaluated), 0);

    // cand_valid wins over a simultaneous no_cand.
    pulse_start();
    no_cand = 1'b1;
    send_cand(brd_hole, 2'd1, 4'd2, 1'b1);
    no_cand = 1'b0;
    check_eq("prio_not_done", int'(best_valid), 0);
    wait_done(n);
    check_eq("prio_found", int'(best_found), 1);
    check_eq("prio_score", int'(best_score), -21);

    // start during COMPARE aborts and clears.
    pulse_start();
    send_cand(brd_a, 2'd1, 4'd0, 1'b0);
    send_cand(brd_a, 2'd1, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("pre_abort_num", int'(num_evaluated), 1);
    pulse_start();
    check_eq("abort_num", int'(num_evaluated), 0);
    check_eq("abort_found", int'(best_found), 0);
    check_eq("abort_ready", int'(cand_ready), 1);

    // Reset at EVAL column 5.
    send_cand(brd_a, 2'd1, 4'd0, 1'b0);
    send_cand(brd_a, 2'd1, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_reset_num", int'(num_evaluated), 1);
    reset = 1'b1;
    #2;
    check_eq("mid_reset_valid", int'(best_valid), 0);
    check_eq("mid_reset_num", int'(num_evaluated), 0);
    check_eq("mid_reset_found", int'(best_found), 0);
    check_eq("mid_reset_ready", int'(cand_ready), 0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_reset_idle", int'(cand_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t01_ai_placement_evaluator.md
Name: t01_ai_placement_evaluator

Overview:
Streaming consumer for the AI placement generator. It accepts one candidate board at a time over a valid/ready handshake, so the 40-entry board arrays are never stored. Each candidate is scored with a column-serial heuristic (lines, aggregate height, holes, bumpiness). The block keeps only the best rotation and x, and reports them to the game FSM when the last candidate has been scored.

Parameters:
W_LINES, 8, reward weight per completed row
W_HEIGHT, 5, penalty weight per unit of aggregate column height
W_HOLES, 7, penalty weight per hole
W_BUMP, 2, penalty weight per unit of adjacent-column height difference
SCORE_W, 16, signed score width; weights must keep |score| < 2^(SCORE_W-1) (no saturation)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: clear best, begin accepting candidates
cand_valid  in  1  candidate present
cand_ready  out  1  evaluator can accept a candidate
cand_board  in  200  merged board; bit row*10+col, row 0 = top
cand_rot  in  2  candidate rotation
cand_x  in  4  candidate x position
cand_last  in  1  qualifies cand_valid: final candidate
no_cand  in  1  pulse in WAIT_CAND: generator found zero placements
best_valid  out  1  result ready; held until next start
best_found  out  1  at least one candidate was evaluated
best_rot  out  2  rotation of best candidate
best_x  out  4  x of best candidate
best_score  out  SCORE_W  signed score of best candidate
num_evaluated  out  6  candidates scored since start

Behaviour:
- Reset: state IDLE; all outputs 0; internal accumulators 0.
- States: IDLE, WAIT_CAND, EVAL, COMPARE, DONE.
- IDLE: on start, go to WAIT_CAND; clear best_*, num_evaluated and best_valid.
- WAIT_CAND: cand_ready=1 (combinational from state). Transfer occurs when cand_valid&&cand_ready; on transfer, latch board, rot, x and last, and go to EVAL with col=0.
  - Lines cleared = count of fully set rows (0..20, 5 bits); computed at capture and registered.
  - no_cand without cand_valid: go to DONE with best_found=0.
  - cand_valid has priority over no_cand when both are high.
- EVAL: one column per cycle, col 0..9 (exactly 10 cycles).
  - height = 20 - top-most set row; empty column = 0.
  - holes = clear cells below the top-most set cell.
  - Accumulate agg_height (8b), holes (8b), bump (8b); bump adds |h[c]-h[c-1]| for c>=1, using a registered previous height.
  - After col 9, go to COMPARE.
- COMPARE (1 cycle):
  - score = W_LINES*lines - W_HEIGHT*agg - W_HOLES*holes - W_BUMP*bump, in signed SCORE_W arithmetic.
  - Replace best if it is the first candidate since start, or if score > best_score (strict).
  - Increment num_evaluated, saturating at 63.
  - If the latched last flag is set, go to DONE; else go to WAIT_CAND.
- Throughput: 12 cycles per candidate (accept, 10 EVAL, COMPARE); cand_ready is low outside WAIT_CAND.
- DONE: best_valid=1 and best_found is valid. Outputs hold until start, which clears them and goes directly to WAIT_CAND.
- start in any non-IDLE state aborts the current evaluation, clears results and goes to WAIT_CAND.
- Asynchronous reset mid-operation returns to IDLE and zeroes all outputs.
- Ties: first-arriving candidate wins (feature below changes this).

Optional Feature:
T01_AI_CENTER_TIEBREAK_EN
- Defined: on score == best_score, replace best if |cand_x-4| < |best_x-4|. Equal distance keeps the incumbent.
- Undefined: ties keep the incumbent. No extra logic.

Decomposition:
- Package t01_ai_pkg: BOARD_ROWS=20, BOARD_COLS=10, default weights, score_t typedef, evaluator state enum.
- Sub-module t01_ai_column_stats: purely combinational. Input is a 20-bit column slice; outputs are height[4:0] and holes[4:0]. The evaluator instantiates one copy, muxed by col.

Test Plan:
1. Reset mid-EVAL: assert reset at EVAL col 5 -> state IDLE, best_valid=0, num_evaluated=0, cand_ready=0.
2. start; single last candidate (row 19 cols 0-3 set, rot=1, x=0) -> after 12 cycles best_valid=1, best_score=-22, best_rot=1, best_x=0, num_evaluated=1.
3. Two candidates: A (row 19 cols 0-3, rot=1, x=0, score -22), then B (col 0 rows 16-19, rot=0, x=0, last, score -28) -> best_rot=1, best_score=-22; cand_ready low for 11 cycles between transfers.
4. Full-row and hole scoring:
   - Row 19 fully set -> lines=1, agg=10, score=-42.
   - Col 0 row 18 set, row 19 clear -> height 2, holes 1, bump 2, score=-21.
5. Ties: two candidates with score -22, x=0 then x=4 -> macro undefined: best_x=0; macro defined: best_x=4.
6. Edge inputs:
   - no_cand pulse after start -> DONE, best_valid=1, best_found=0, num_evaluated=0.
   - start during COMPARE -> results cleared, WAIT_CAND.
